pnr_pulse_gen: RTL and testbench

Synthetic detector-signal generator for the PNR channel. It drives the two 14-bit DAC outputs with a programmable trigger edge and a photon-number-resolved pulse at a programmable delay. This lets the trigger/PNR acquisition path be exercised in loopback, either through the DAC-to-ADC cable or digitally. It sits beside the PNR receiver on the ADC clock domain and is configured from the same register bank.

---
 rtl/pnr_pkg.sv | 28 ++
 rtl/pnr_level_calc.sv | 33 +++
 rtl/pnr_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_pnr_pulse_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pnr_pkg.sv
// Shared constants, FSM state type and a signed saturation helper for the
// PNR synthetic pulse generator.
package pnr_pkg;

  localparam int PNR_DW = 14;
  localparam int PNR_CW = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pnr_state_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned        w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/pnr_level_calc.sv
// PNR pulse amplitude: baseline + photon_num * photon_step, computed with
// five guard bits and saturated back to the DAC sample width.
module pnr_level_calc
  import pnr_pkg::*;
#(
  parameter int DW = PNR_DW
) (
  input  logic signed [DW-1:0] baseline_i,
  input  logic signed [DW-1:0] step_i,
  input  logic        [3:0]    num_i,
  output logic signed [DW-1:0] level_o
);

  localparam int XW = DW + 5;

  logic signed [XW-1:0] base_x;
  logic signed [XW-1:0] step_x;
  logic signed [XW-1:0] num_x;
  logic signed [XW-1:0] prod_x;
  logic signed [XW-1:0] sum_x;

  // 15 * full-scale step plus baseline fits in DW+5 bits, so no wrap occurs
  // before the clamp.
  always_comb begin
    base_x  = {{5{baseline_i[DW-1]}}, baseline_i};
    step_x  = {{5{step_i[DW-1]}}, step_i};
    num_x   = {{(XW-4){1'b0}}, num_i};
    prod_x  = num_x * step_x;
    sum_x   = base_x + prod_x;
    level_o = DW'(saturate(64'(sum_x), DW));
  end

endmodule

// File: rtl/pnr_pulse_gen.sv
// Synthetic trigger + photon-number-resolved pulse generator on the ADC clock.
// Frames of L cycles, config latched at frame accept, all outputs registered.
module pnr_pulse_gen
  import pnr_pkg::*;
#(
  parameter int DW = PNR_DW,
  parameter int CW = PNR_CW
) (
  input  logic                 ADC_CLK,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  input  logic                 single_i,
  input  logic        [CW-1:0] period_i,
  input  logic        [CW-1:0] trig_width_i,
  input  logic signed [DW-1:0] trig_high_i,
  input  logic signed [DW-1:0] trig_low_i,
  input  logic        [CW-1:0] pnr_delay_i,
  input  logic        [CW-1:0] pnr_width_i,
  input  logic        [3:0]    photon_num_i,
  input  logic signed [DW-1:0] photon_step_i,
  input  logic signed [DW-1:0] baseline_i,
  output logic signed [DW-1:0] trig_dac_o,
  output logic signed [DW-1:0] pnr_dac_o,
  output logic                 frame_start_o,
  output logic                 busy_o,
  output logic        [CW-1:0] frame_cnt_o
);

  localparam logic [CW:0]   F_ONE   = (CW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pnr_state_e state_q;
  logic [CW:0] f_q;

  // Latched frame configuration.
  logic        [CW:0]   len_q;
  logic        [CW-1:0] tw_q;
  logic signed [DW-1:0] th_q;
  logic signed [DW-1:0] tl_q;
  logic        [CW-1:0] pd_q;
  logic        [CW:0]   pend_q;
  logic signed [DW-1:0] lvl_q;
  logic signed [DW-1:0] base_q;

  logic signed [DW-1:0] trig_q;
  logic signed [DW-1:0] pnr_q;
  logic                 fs_q;
  logic                 busy_q;
  logic        [CW-1:0] cnt_q;

  logic signed [DW-1:0] level_d;
  logic        [CW:0]   pend_d;
  logic        [CW:0]   len_d;
  logic                 last_d;
  logic                 accept_d;
  logic                 in_trig_d;
  logic                 in_pnr_d;

  pnr_level_calc #(.DW(DW)) u_level (
    .baseline_i (baseline_i),
    .step_i     (photon_step_i),
    .num_i      (photon_num_i),
    .level_o    (level_d)
  );

  // Frame length and window ends carry one extra bit so delay+width and the
  // cycle index never wrap.
  always_comb begin
    pend_d = {1'b0, pnr_delay_i} + {1'b0, pnr_width_i};
    len_d  = {1'b0, period_i};
    if ({1'b0, trig_width_i} > len_d) begin
      len_d = {1'b0, trig_width_i};
    end
    if (pend_d > len_d) begin
      len_d = pend_d;
    end
    if (len_d == '0) begin
      len_d = F_ONE;
    end
    last_d    = (f_q == len_q - F_ONE);
    accept_d  = (state_q == ST_IDLE) ? (enable_i | single_i) : (last_d & enable_i);
    in_trig_d = (f_q < {1'b0, tw_q});
    in_pnr_d  = (f_q >= {1'b0, pd_q}) && (f_q < pend_q);
  end

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      len_q   <= F_ONE;
      tw_q    <= '0;
      th_q    <= '0;
      tl_q    <= '0;
      pd_q    <= '0;
      pend_q  <= '0;
      lvl_q   <= '0;
      base_q  <= '0;
      trig_q  <= '0;
      pnr_q   <= '0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept_d) begin
        len_q  <= len_d;
        tw_q   <= trig_width_i;
        th_q   <= trig_high_i;
        tl_q   <= trig_low_i;
        pd_q   <= pnr_delay_i;
        pend_q <= pend_d;
        lvl_q  <= level_d;
        base_q <= baseline_i;
      end

      case (state_q)
        ST_IDLE: begin
          f_q <= '0;
          if (accept_d) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_d) begin
            f_q <= '0;
            if (!enable_i) begin
              state_q <= ST_IDLE;
            end
          end else begin
            f_q <= f_q + F_ONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Outputs lag the cycle index by one register stage.
      if (state_q == ST_RUN) begin
        trig_q <= in_trig_d ? th_q : tl_q;
        pnr_q  <= in_pnr_d ? lvl_q : base_q;
        fs_q   <= (f_q == '0);
        busy_q <= 1'b1;
        if (f_q == '0) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else begin
        trig_q <= trig_low_i;
        pnr_q  <= baseline_i;
        fs_q   <= 1'b0;
        busy_q <= 1'b0;
      end
    end
  end

  assign trig_dac_o    = trig_q;
  assign pnr_dac_o     = pnr_q;
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;
  assign frame_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pnr_pulse_gen.sv
// Bench for pnr_pulse_gen: directed and randomized frames checked against a
// frame-level reference model; a 4-bit-counter instance covers counter wrap.
module tb_pnr_pulse_gen;

  localparam int DW  = 14;
  localparam int CW  = 32;
  localparam int CWW = 4;
  localparam int EW  = 2 * DW + 2;

  typedef struct {
    int period;
    int tw;
    int th;
    int tl;
    int pd;
    int pw;
    int pn;
    int ps;
    int base;
  } cfg_t;

  // clock / reset
  logic ADC_CLK;
  logic rstn_i;
  initial ADC_CLK = 1'b0;
  always #5 ADC_CLK = ~ADC_CLK;

  logic                 enable_i, single_i;
  logic        [CW-1:0] period_i, trig_width_i, pnr_delay_i, pnr_width_i;
  logic signed [DW-1:0] trig_high_i, trig_low_i, photon_step_i, baseline_i;
  logic        [3:0]    photon_num_i;
  logic signed [DW-1:0] trig_dac_o, pnr_dac_o;
  logic                 frame_start_o, busy_o;
  logic        [CW-1:0] frame_cnt_o;

  logic                 w_en;
  logic signed [DW-1:0] w_trig, w_pnr;
  logic                 w_fs, w_busy;
  logic        [CWW-1:0] w_cnt;

  pnr_pulse_gen #(.DW(DW), .CW(CW)) dut (
    .ADC_CLK       (ADC_CLK),
    .rstn_i        (rstn_i),
    .enable_i      (enable_i),
    .single_i      (single_i),
    .period_i      (period_i),
    .trig_width_i  (trig_width_i),
    .trig_high_i   (trig_high_i),
    .trig_low_i    (trig_low_i),
    .pnr_delay_i   (pnr_delay_i),
    .pnr_width_i   (pnr_width_i),
    .photon_num_i  (photon_num_i),
    .photon_step_i (photon_step_i),
    .baseline_i    (baseline_i),
    .trig_dac_o    (trig_dac_o),
    .pnr_dac_o     (pnr_dac_o),
    .frame_start_o (frame_start_o),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  pnr_pulse_gen #(.DW(DW), .CW(CWW)) dut_w (
    .ADC_CLK       (ADC_CLK),
    .rstn_i        (rstn_i),
    .enable_i      (w_en),
    .single_i      (1'b0),
    .period_i      ('0),
    .trig_width_i  ('0),
    .trig_high_i   ('0),
    .trig_low_i    ('0),
    .pnr_delay_i   ('0),
    .pnr_width_i   ('0),
    .photon_num_i  ('0),
    .photon_step_i ('0),
    .baseline_i    ('0),
    .trig_dac_o    (w_trig),
    .pnr_dac_o     (w_pnr),
    .frame_start_o (w_fs),
    .busy_o        (w_busy),
    .frame_cnt_o   (w_cnt)
  );

  int n_checks;
  int n_errors;
  int cnt_exp;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic cfg_t mk_cfg(int period, int tw, int th, int tl, int pd,
                                  int pw, int pn, int ps, int base);
    cfg_t c;
    c.period = period; c.tw = tw; c.th = th; c.tl = tl; c.pd = pd;
    c.pw = pw; c.pn = pn; c.ps = ps; c.base = base;
    return c;
  endfunction

  function automatic int model_len(cfg_t c);
    int l;
    l = c.period;
    if (c.tw > l) l = c.tw;
    if (c.pd + c.pw > l) l = c.pd + c.pw;
    if (l < 1) l = 1;
    return l;
  endfunction

  function automatic int model_level(cfg_t c);
    int v;
    v = c.base + c.pn * c.ps;
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v;
  endfunction

  function automatic logic [EW-1:0] pack(int trig, int pnr, bit fs, bit busy);
    logic [DW-1:0] t;
    logic [DW-1:0] p;
    t = trig[DW-1:0];
    p = pnr[DW-1:0];
    return {t, p, fs, busy};
  endfunction

  function automatic logic [EW-1:0] model_cycle(cfg_t c, int f);
    int t;
    int p;
    t = (f < c.tw) ? c.th : c.tl;
    p = (f >= c.pd && f < c.pd + c.pw) ? model_level(c) : c.base;
    return pack(t, p, (f == 0), 1'b1);
  endfunction

  function automatic logic [EW-1:0] got_word();
    return {trig_dac_o, pnr_dac_o, frame_start_o, busy_o};
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.period = int'($urandom_range(0, 12));
    c.tw     = int'($urandom_range(0, 12));
    c.th     = int'($urandom_range(0, 16383)) - 8192;
    c.tl     = int'($urandom_range(0, 16383)) - 8192;
    c.pd     = int'($urandom_range(0, 10));
    c.pw     = int'($urandom_range(0, 6));
    c.pn     = int'($urandom_range(0, 15));
    c.ps     = int'($urandom_range(0, 16383)) - 8192;
    c.base   = int'($urandom_range(0, 16383)) - 8192;
    return c;
  endfunction

  // driver tasks
  task automatic apply_cfg(input cfg_t c);
    period_i      = CW'(c.period);
    trig_width_i  = CW'(c.tw);
    trig_high_i   = DW'(c.th);
    trig_low_i    = DW'(c.tl);
    pnr_delay_i   = CW'(c.pd);
    pnr_width_i   = CW'(c.pw);
    photon_num_i  = 4'(c.pn);
    photon_step_i = DW'(c.ps);
    baseline_i    = DW'(c.base);
  endtask

  // Frame 0 uses ca, later frames cb; cb is driven after sample chg_s (-1: never).
  // single_i pulses after sample late_s; enable drops drop_off samples into
  // the final frame (0 = right after the previous frame ends).
  task automatic run_frames(input string name, input cfg_t ca, input cfg_t cb,
                            input int nf, input bit cont, input bit both,
                            input int chg_s, input int late_s, input int drop_off);
    int total;
    int last_start;
    int drop_s;
    int l;
    cfg_t fc;
    exp_q.delete();
    total = 0;
    last_start = 0;
    for (int i = 0; i < nf; i++) begin
      fc = (i == 0) ? ca : cb;
      l = model_len(fc);
      last_start = total;
      for (int f = 0; f < l; f++) exp_q.push_back(model_cycle(fc, f));
      total += l;
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(cb.tl, cb.base, 1'b0, 1'b0));
    drop_s = cont ? (last_start - 1 + drop_off) : -2;

    @(negedge ADC_CLK);
    apply_cfg(ca);
    enable_i = cont;
    single_i = !cont || both;
    @(negedge ADC_CLK);
    single_i = 1'b0;
    check({name, " latency"}, got_word(), pack(ca.tl, ca.base, 1'b0, 1'b0));
    if (drop_s == -1) enable_i = 1'b0;
    for (int s = 0; s < total + 3; s++) begin
      @(negedge ADC_CLK);
      check($sformatf("%s s%0d", name, s), got_word(), exp_q.pop_front());
      single_i = (s == late_s);
      if (s == chg_s) apply_cfg(cb);
      if (s == drop_s) enable_i = 1'b0;
    end
    single_i = 1'b0;
    enable_i = 1'b0;
    cnt_exp += nf;
    check({name, " frame_cnt"}, frame_cnt_o, cnt_exp);
  endtask

  initial begin
    cfg_t ca, cb;
    int la, lb, nf, total, chg, late, doff;
    bit cont, both;
    n_checks = 0;
    n_errors = 0;
    cnt_exp  = 0;
    rstn_i   = 1'b0;
    enable_i = 1'b0;
    single_i = 1'b0;
    w_en     = 1'b0;
    apply_cfg(mk_cfg(0, 0, 0, 123, 0, 0, 0, 0, -45));

    repeat (2) @(negedge ADC_CLK);
    check("reset outputs", got_word(), '0);
    check("reset frame_cnt", frame_cnt_o, 0);
    check("reset wrap cnt", w_cnt, 0);
    rstn_i = 1'b1;
    @(negedge ADC_CLK);
    check("idle after reset", got_word(), pack(123, -45, 1'b0, 1'b0));

    ca = mk_cfg(20, 4, 4000, -100, 6, 3, 2, 500, 0);
    run_frames("basic", ca, ca, 1, 1'b0, 1'b0, -1, -1, 0);

    ca = mk_cfg(10, 3, 3000, -50, 2, 2, 1, 700, 100);
    run_frames("cont", ca, ca, 4, 1'b1, 1'b0, -1, -1, 5);

    ca = mk_cfg(8, 2, 1000, 0, 1, 3, 15, 2000, 1000);
    run_frames("sat_pos", ca, ca, 1, 1'b0, 1'b0, -1, -1, 0);
    ca.ps = -2000;
    run_frames("sat_neg", ca, ca, 1, 1'b0, 1'b0, -1, -1, 0);

    ca = mk_cfg(5, 2, 2500, -10, 8, 4, 3, 100, 20);
    run_frames("clamp", ca, ca, 1, 1'b0, 1'b0, -1, -1, 0);

    ca = mk_cfg(10, 2, 2000, 0, 4, 4, 3, 300, 0);
    cb = ca;
    cb.pn = 7;
    run_frames("midcfg", ca, cb, 2, 1'b1, 1'b0, 5, -1, 3);
    run_frames("late_single", ca, ca, 1, 1'b0, 1'b0, -1, 3, 0);

    ca = mk_cfg(0, 0, 700, -700, 0, 0, 0, 0, 5);
    run_frames("min_len", ca, ca, 5, 1'b1, 1'b1, -1, 2, 0);

    for (int it = 0; it < 16; it++) begin
      ca   = rand_cfg();
      cb   = ca;
      chg  = -1;
      la   = model_len(ca);
      cont = 1'($urandom_range(0, 1));
      both = cont ? 1'($urandom_range(0, 1)) : 1'b0;
      nf   = cont ? int'($urandom_range(1, 3)) : 1;
      if ($urandom_range(0, 1) == 1 && la >= 2) begin
        cb  = rand_cfg();
        chg = int'($urandom_range(0, la - 2));
      end
      lb    = model_len(cb);
      total = la + (nf - 1) * lb;
      late  = ($urandom_range(0, 1) == 1 && total >= 2) ? int'($urandom_range(0, total - 2)) : -1;
      doff  = int'($urandom_range(0, ((nf == 1) ? la : lb) - 1));
      run_frames($sformatf("rand%0d", it), ca, cb, nf, cont, both, chg, late, doff);
    end

    // Asynchronous reset in the middle of a PNR pulse.
    ca = mk_cfg(20, 4, 4000, -100, 6, 3, 2, 500, 0);
    @(negedge ADC_CLK);
    apply_cfg(ca);
    single_i = 1'b1;
    @(negedge ADC_CLK);
    single_i = 1'b0;
    repeat (8) @(negedge ADC_CLK);
    check("pre-reset pulse", got_word(), pack(-100, 1000, 1'b0, 1'b1));
    #2;
    rstn_i = 1'b0;
    #1;
    check("async reset outputs", got_word(), '0);
    check("async reset frame_cnt", frame_cnt_o, 0);
    cnt_exp = 0;
    @(negedge ADC_CLK);
    rstn_i = 1'b1;
    @(negedge ADC_CLK);
    check("idle after async reset", got_word(), pack(-100, 0, 1'b0, 1'b0));
    run_frames("post_reset", ca, ca, 1, 1'b0, 1'b0, -1, -1, 0);

    // Counter wrap on the narrow-counter instance; L = 1 so every cycle is a frame.
    @(negedge ADC_CLK);
    w_en = 1'b1;
    @(negedge ADC_CLK);
    check("wrap latency", {w_fs, w_busy}, 2'b00);
    for (int j = 0; j < 20; j++) begin
      @(negedge ADC_CLK);
      check($sformatf("wrap fs%0d", j), {w_fs, w_busy, w_trig, w_pnr}, {2'b11, {(2*DW){1'b0}}});
      check($sformatf("wrap cnt%0d", j), w_cnt, (j + 1) % 16);
    end
    w_en = 1'b0;
    @(negedge ADC_CLK);
    check("wrap last frame", {w_fs, w_busy}, 2'b11);
    check("wrap last cnt", w_cnt, 21 % 16);
    @(negedge ADC_CLK);
    check("wrap idle", {w_fs, w_busy}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
